// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and trace format for the multiport register file
package rf_pkg;
   localparam int    DEF_DATA_W = 32;
   localparam int    DEF_ADDR_W = 5;
   localparam int    DEF_NUM_RD = 2;
   localparam string TRACE_FMT  = "%0t@%h: $%0d <= %h";
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy-bit scoreboard with reservation accept and busy count
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wa_en,
   input  logic [ADDR_W-1:0]        wa_addr,
   input  logic                     wb_en,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic                     rsv_ok,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [ADDR_W:0]          busy_cnt
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy_q, busy_d, wr_hit;
   logic [ADDR_W:0]  busy_cnt_q, busy_cnt_d;

   always_comb begin
      wr_hit = '0;
      if (wa_en) wr_hit[wa_addr] = 1'b1;
      if (wb_en) wr_hit[wb_addr] = 1'b1;

      rsv_ok = rsv_en && (rsv_addr != '0) && (!busy_q[rsv_addr] || wr_hit[rsv_addr]);

      // Reservation is applied after the write clear so a re-reserve keeps the bit set
      busy_d = busy_q & ~wr_hit;
      if (rsv_ok) busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;

      busy_cnt_d = '0;
      for (int k = 0; k < DEPTH; k++)
         busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[k]};

      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++)
         rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]] && !wr_hit[rd_addr[i*ADDR_W +: ADDR_W]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;
endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - multiport register file with write bypass and scoreboard; RF_TRACE_EN enables write trace
module rf_multiport
   import rf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wa_en,
   input  logic [ADDR_W-1:0]        wa_addr,
   input  logic [DATA_W-1:0]        wa_data,
   input  logic [31:0]              wa_pc,
   input  logic                     wb_en,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic [31:0]              wb_pc,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic                     rsv_ok,
   output logic [ADDR_W:0]          busy_cnt
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      // Port B first so port A overwrites it on a same-address collision
      if (wb_en && wb_addr != '0) mem_d[wb_addr] = wb_data;
      if (wa_en && wa_addr != '0) mem_d[wa_addr] = wa_data;
   end

   always_ff @(posedge clk) begin
      if (reset) mem_q <= '{default: '0};
      else       mem_q <= mem_d;
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_addr[i*ADDR_W +: ADDR_W] == '0)
            rd_data[i*DATA_W +: DATA_W] = '0;
         else if (wa_en && wa_addr == rd_addr[i*ADDR_W +: ADDR_W])
            rd_data[i*DATA_W +: DATA_W] = wa_data;
         else if (wb_en && wb_addr == rd_addr[i*ADDR_W +: ADDR_W])
            rd_data[i*DATA_W +: DATA_W] = wb_data;
         else
            rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
      end
   end

   rf_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rd_addr  (rd_addr),
      .rsv_ok   (rsv_ok),
      .rd_busy  (rd_busy),
      .busy_cnt (busy_cnt)
   );

`ifdef RF_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wa_en && wa_addr != '0)
            $display("%s", $sformatf(TRACE_FMT, $time, wa_pc, wa_addr, wa_data));
         if (wb_en && wb_addr != '0 && !(wa_en && wa_addr == wb_addr))
            $display("%s", $sformatf(TRACE_FMT, $time, wb_pc, wb_addr, wb_data));
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^{wa_pc, wb_pc};
`endif
endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth is 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of read ports (1..4).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port reset: input, 1 bit, synchronous, active-high reset.
REQ-007 Port rd_addr: input, NUM_RD*ADDR_W bits, read addresses; port i occupies slice i.
REQ-008 Port rd_data: output, NUM_RD*DATA_W bits, read data; port i occupies slice i.
REQ-009 Port rd_busy: output, NUM_RD bits, per-read-port "value not yet produced" flag.
REQ-010 Ports wa_en (1), wa_addr (ADDR_W), wa_data (DATA_W) and wa_pc (32): inputs, write port A (writeback stage), with the PC used for trace.
REQ-011 Ports wb_en (1), wb_addr (ADDR_W), wb_data (DATA_W) and wb_pc (32): inputs, write port B (long-latency unit).
REQ-012 Ports rsv_en (1) and rsv_addr (ADDR_W): inputs, request to mark a destination register busy.
REQ-013 Port rsv_ok: output, 1 bit, combinational; the reservation is accepted this cycle.
REQ-014 Port busy_cnt: output, ADDR_W+1 bits, registered count of busy registers.

Function
REQ-015 Reads SHALL be combinational: rd_data[i] = mem[rd_addr[i]], subject to REQ-016 and REQ-017.
REQ-016 Write bypass SHALL apply: if a read address equals an enabled write address this cycle, the read returns that write's data; port A takes precedence over port B.
REQ-017 Address 0 SHALL always read 0, ignore writes, never be busy, and never be reservable.
REQ-018 Writes SHALL commit at the rising edge; when wa and wb target the same nonzero address, wa_data is stored.
REQ-019 Scoreboard bit busy[r] SHALL be cleared at the edge on which any enabled write to r commits.
REQ-020 rsv_ok SHALL equal rsv_en && rsv_addr!=0 && (!busy[rsv_addr] || write to rsv_addr this cycle).
REQ-021 An accepted reservation SHALL set busy[rsv_addr] at the edge; set wins over a same-cycle clear (WAW re-reserve).
REQ-022 A rejected reservation SHALL cause no state change.
REQ-023 rd_busy[i] SHALL equal busy[rd_addr[i]] && no enabled write to rd_addr[i] this cycle.
REQ-024 busy_cnt SHALL equal the popcount of busy after each edge; it ranges from 0 to 2**ADDR_W-1 and never wraps.

Reset
REQ-025 On reset all registers, all busy bits and busy_cnt SHALL be 0 at the next edge.
REQ-026 Reset SHALL override same-cycle writes and reservations; rd_data then shows the bypassed values only combinationally.

Configuration
REQ-027 With macro RF_TRACE_EN defined, each committed write to a nonzero address SHALL print "<time>@<pc hex>: $<addr dec> <= <data hex>", port A before port B; a port-B write shadowed by port A SHALL NOT print.
REQ-028 With RF_TRACE_EN undefined, no display code SHALL be compiled, and function SHALL be identical to the traced build.

Structure
REQ-029 Package rf_pkg SHALL hold the default DATA_W/ADDR_W/NUM_RD constants and the trace format string.
REQ-030 The busy bits, rsv_ok logic and busy_cnt SHALL live in sub-module rf_scoreboard; the storage and bypass logic SHALL live in the top level.

Verification
REQ-031 Reset, then read all addresses -> all rd_data 0, busy_cnt 0, rd_busy 0.
REQ-032 wa writes 0xDEADBEEF to r5 while rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF in the same cycle; r5 holds it after the edge.
REQ-033 wa and wb both write r7 (0x11, 0x22) in the same cycle -> r7=0x11; the trace shows only the port-A line.
REQ-034 rsv r9 -> busy_cnt=1; rsv r9 again -> rsv_ok=0; wb writes r9 together with a rsv of r9 -> rsv_ok=1, busy stays 1, r9 updated.
REQ-035 Write 0x5 to r0 and rsv r0 -> rd_data for r0 is 0, rsv_ok=0, busy_cnt unchanged.
REQ-036 rsv r3, then assert reset together with a wa write to r3 -> after the edge r3=0, busy[3]=0, busy_cnt=0.
